// File: rtl/scan_mux_reg.sv
// Registered N-channel multiplexer with direct select and autonomous channel scan.
// Scan mode holds each channel SCAN_HOLD enabled cycles and pulses scan_wrap on the last one.
`timescale 1ns/1ps
module scan_mux_reg #(
  parameter int unsigned N_CH      = 16,
  parameter int unsigned W         = 1,
  parameter int unsigned SCAN_HOLD = 4,
  localparam int unsigned SEL_W    = $clog2(N_CH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic [N_CH*W-1:0]   in_bus,
  input  logic [SEL_W-1:0]    sel,
  output logic [W-1:0]        y,
  output logic [SEL_W-1:0]    y_sel,
  output logic                y_valid,
  output logic                scan_wrap
);

  localparam int unsigned CNT_W = (SCAN_HOLD > 1) ? $clog2(SCAN_HOLD) : 1;

  logic [W-1:0]     r_y;
  logic [SEL_W-1:0] r_y_sel;
  logic             r_y_valid;
  logic             r_scan_wrap;
  logic [SEL_W-1:0] r_cur_sel;
  logic [CNT_W-1:0] r_hold_cnt;
  logic             r_scan_active;

  logic [SEL_W-1:0] w_ch_eff;
  logic [CNT_W-1:0] w_cnt_eff;
  logic [SEL_W-1:0] w_src;
  logic [W-1:0]     w_mux;
  logic             w_in_range;
  logic             w_last_cnt;
  logic             w_last_ch;

  // A fresh scan entry behaves as hold cycle 0 of channel 0
  assign w_ch_eff   = r_scan_active ? r_cur_sel  : '0;
  assign w_cnt_eff  = r_scan_active ? r_hold_cnt : '0;
  assign w_src      = mode ? w_ch_eff : sel;
  assign w_in_range = ({1'b0, sel} < (SEL_W+1)'(N_CH));
  assign w_last_cnt = (w_cnt_eff == CNT_W'(SCAN_HOLD - 1));
  assign w_last_ch  = (w_ch_eff == SEL_W'(N_CH - 1));

  // Compare-based mux so out-of-range selects never index past in_bus
  always_comb begin
    w_mux = '0;
    for (int k = 0; k < int'(N_CH); k++) begin
      if (w_src == SEL_W'(k)) w_mux = in_bus[k*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y           <= '0;
      r_y_sel       <= '0;
      r_y_valid     <= 1'b0;
      r_scan_wrap   <= 1'b0;
      r_cur_sel     <= '0;
      r_hold_cnt    <= '0;
      r_scan_active <= 1'b0;
    end else if (!en) begin
      r_y_valid   <= 1'b0;
      r_scan_wrap <= 1'b0;
    end else if (!mode) begin
      r_y           <= w_in_range ? w_mux : '0;
      r_y_sel       <= sel;
      r_y_valid     <= w_in_range;
      r_scan_active <= 1'b0;
      r_scan_wrap   <= 1'b0;
    end else begin
      r_y           <= w_mux;
      r_y_sel       <= w_ch_eff;
      r_y_valid     <= 1'b1;
      r_scan_active <= 1'b1;
      r_scan_wrap   <= w_last_ch && w_last_cnt;
      if (w_last_cnt) begin
        r_hold_cnt <= '0;
        r_cur_sel  <= w_last_ch ? '0 : w_ch_eff + SEL_W'(1);
      end else begin
        r_hold_cnt <= w_cnt_eff + CNT_W'(1);
        r_cur_sel  <= w_ch_eff;
      end
    end
  end

  assign y         = r_y;
  assign y_sel     = r_y_sel;
  assign y_valid   = r_y_valid;
  assign scan_wrap = r_scan_wrap;

endmodule
